lcd_hd44780_fifo: RTL and testbench

Buffered, parametrised HD44780-class character-LCD controller on an Avalon-MM slave port, replacing the unbuffered 16x2 driver. CPU writes of instruction/data bytes go into a command FIFO. A sequencer drains the FIFO onto the LCD bus with programmable setup, enable-pulse and hold timing, and a post-command delay. Sits between the system interconnect and the board LCD header.

---
 rtl/lcd_hd44780_fifo_if.sv | 20 ++
 rtl/lcd_hd44780_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_lcd_hd44780_fifo.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_fifo_if.sv
// Avalon-MM slave bundle for the buffered HD44780 character-LCD controller.
interface lcd_hd44780_fifo_if;
    logic       address;
    logic       chipselect;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/lcd_hd44780_fifo.sv
// Buffered HD44780 controller: CPU bytes queue in a FIFO and are replayed onto the LCD bus.
// Optional LCD_BUSY_POLL_EN replaces the fixed post-command delay with busy-flag polling.
//
// state | meaning
// IDLE  | waiting for a queued entry; pops and latches it
// SETUP | RS/RW/DATA stable before the strobe
// PULSE | LCD_EN high
// HOLD  | LCD_EN low, bus still held
// WAIT  | fixed post-command delay, bus released (unused when polling)
module lcd_hd44780_fifo #(
    parameter int SETUP_CYC    = 4,
    parameter int EN_CYC       = 12,
    parameter int HOLD_CYC     = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic              clk,
    input  logic              reset,
    lcd_hd44780_fifo_if.slave bus,
    inout  wire  [7:0]        LCD_DATA,
    output logic              LCD_ON,
    output logic              LCD_BLON,
    output logic              LCD_EN,
    output logic              LCD_RS,
    output logic              LCD_RW
);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > CLR_WAIT_CYC) ? MAX_C : CLR_WAIT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              cnt_zero;

    logic [8:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW:0]  wr_ptr, rd_ptr, fill;
    logic              full, empty, push, pop;
    logic [8:0]        free_cnt;
    logic [7:0]        free_sat;

    logic              lat_rs;
    logic [7:0]        lat_data;
    logic              on_q;
    logic              xfer, drive;
    logic              status_b5;
    logic              read_unused;

    assign read_unused = bus.read;

    // Pointer MSB is the wrap bit: equal indices with differing wrap bits means full.
    assign fill     = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign free_cnt = 9'(FIFO_DEPTH) - 9'(fill);
    assign free_sat = free_cnt[8] ? 8'hFF : free_cnt[7:0];

    assign bus.waitrequest = bus.chipselect & bus.write & full;
    assign push            = bus.chipselect & bus.write & ~full;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[FIFO_AW-1:0]] <= {bus.address, bus.writedata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lat_rs   <= 1'b0;
            lat_data <= 8'h00;
            on_q     <= 1'b0;
        end else begin
            on_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                <= rd_ptr + 1'b1;
                {lat_rs, lat_data}    <= mem[rd_ptr[FIFO_AW-1:0]];
            end
        end
    end

`ifdef LCD_BUSY_POLL_EN
    logic poll_q, busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            if (state == S_PULSE && cnt_zero && poll_q)
                busy_q <= LCD_DATA[7];
            if (state == S_HOLD && cnt_zero)
                poll_q <= !(poll_q && !busy_q);
        end
    end

    assign status_b5 = busy_q;
    assign drive     = xfer & ~poll_q;
    assign LCD_RW    = xfer & poll_q;
    assign LCD_RS    = xfer & ~poll_q & lat_rs;
`else
    localparam logic [CW-1:0] CMD_LD = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LD = CW'(CLR_WAIT_CYC - 1);
    logic is_clr;

    // Clear display and return home need the long settle time.
    assign is_clr    = !lat_rs && (lat_data == 8'h01 || lat_data == 8'h02);
    assign status_b5 = (state != S_IDLE);
    assign drive     = xfer;
    assign LCD_RW    = 1'b0;
    assign LCD_RS    = xfer & lat_rs;
`endif

    assign cnt_zero = (cnt == '0);
    assign xfer     = (state == S_SETUP) || (state == S_PULSE) || (state == S_HOLD);
    assign LCD_EN   = (state == S_PULSE);
    assign LCD_DATA = drive ? lat_data : 8'bz;
    assign LCD_ON   = on_q;
    assign LCD_BLON = on_q;

    assign bus.readdata = bus.address ? free_sat : {full, empty, status_b5, 5'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_PULSE;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
`ifdef LCD_BUSY_POLL_EN
                    if (poll_q && !busy_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end
`else
                    state_d = S_WAIT;
                    cnt_d   = is_clr ? CLR_LD : CMD_LD;
`endif
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt_zero)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lcd_hd44780_fifo.sv
// Directed bench for lcd_hd44780_fifo with shortened post-command delays (CMD 20, CLR 60).
module tb_lcd_hd44780_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] lcd_data;
    logic       lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw;

    lcd_hd44780_fifo_if bus ();

    lcd_hd44780_fifo #(
        .SETUP_CYC(4), .EN_CYC(12), .HOLD_CYC(4),
        .FIFO_DEPTH(16), .CMD_WAIT_CYC(20), .CLR_WAIT_CYC(60)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .LCD_DATA(lcd_data),
        .LCD_ON(lcd_on), .LCD_BLON(lcd_blon), .LCD_EN(lcd_en),
        .LCD_RS(lcd_rs), .LCD_RW(lcd_rw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         rise;
        int         en_len;
        int         setup;
        int         hold;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } strobe_t;

    strobe_t    recs[$];
    strobe_t    cur;
    int         phase = 0;
    int         pre_cnt = 0;
    logic [9:0] pre_val = '0;
    logic [9:0] v;
    int         poll_seen = 0;

`ifdef LCD_BUSY_POLL_EN
    // LCD model: reports busy for the first three polls, ready afterwards.
    assign lcd_data = (lcd_rw && lcd_en) ? ((poll_seen <= 3) ? 8'h80 : 8'h00) : 8'bz;
`endif

    always @(negedge clk) begin
        v = {lcd_rs, lcd_rw, lcd_data};
        if (lcd_en) begin
            if (phase != 1) begin
                if (phase == 2) recs.push_back(cur);
                cur.rise   = cyc;
                cur.rs     = lcd_rs;
                cur.rw     = lcd_rw;
                cur.data   = lcd_data;
                cur.setup  = (v == pre_val) ? pre_cnt : 0;
                cur.en_len = 1;
                cur.hold   = 0;
                phase      = 1;
                if (lcd_rw) poll_seen++;
            end else begin
                cur.en_len++;
            end
            pre_cnt = 0;
        end else begin
            if (phase == 1) phase = 2;
            if (phase == 2) begin
                if (v == {cur.rs, cur.rw, cur.data}) cur.hold++;
                else begin
                    recs.push_back(cur);
                    phase = 0;
                end
            end
            if (v == pre_val) pre_cnt++;
            else pre_cnt = 1;
        end
        pre_val = v;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int wr_cyc;

    task automatic do_write(input logic a, input logic [7:0] d, output int stall);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        stall = 0;
        #1;
        while (bus.waitrequest && stall < 200) begin
            @(negedge clk);
            #1;
            stall++;
        end
        if (stall >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_stall_bound: got %0d expected <200", stall);
        end
        wr_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic bus_idle();
        #1;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 1'b0;
    endtask

    task automatic do_read(input logic a, output logic [7:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.write      = 1'b0;
        bus.address    = a;
        #1;
        d = bus.readdata;
        #1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 1'b0;
    endtask

    task automatic wait_recs(input int n, input int bound, input string name);
        int t;
        t = 0;
        while (recs.size() < n && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (recs.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d strobes expected %0d", name, recs.size(), n);
        end
    endtask

    typedef struct {
        logic       addr;
        logic [7:0] data;
        int         gap;
    } vec_t;

    vec_t       vecs[7];
    int         st;
    logic [7:0] rd;
    int         t;
    int         nrw;

    initial begin
        // Gap = 1 + 4 + 12 + 4 + wait, wait = 60 for RS=0 bytes 0x01/0x02 else 20.
        vecs[0] = '{1'b0, 8'h38, 41};
        vecs[1] = '{1'b0, 8'h01, 81};
        vecs[2] = '{1'b1, 8'h41, 41};
        vecs[3] = '{1'b0, 8'h02, 81};
        vecs[4] = '{1'b1, 8'h01, 41};
        vecs[5] = '{1'b0, 8'h03, 41};
        vecs[6] = '{1'b0, 8'h0C, 0};

        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 1'b0;
        bus.writedata  = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check("rst_readdata", bus.readdata, 8'h40);
        check("rst_waitrequest", bus.waitrequest, 0);
        check("rst_en", lcd_en, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_on", lcd_on, 0);
        check("rst_blon", lcd_blon, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("on_before_edge", lcd_on, 0);
        @(negedge clk);
        #1;
        check("on_after_edge", lcd_on, 1);
        check("blon_after_edge", lcd_blon, 1);
        do_read(1'b0, rd);
        check("status_after_rst", rd, 8'h40);
        do_read(1'b1, rd);
        check("free_after_rst", rd, 16);
        recs.delete();

`ifdef LCD_BUSY_POLL_EN
        do_write(1'b0, 8'h38, st);
        bus_idle();
        wait_recs(5, 500, "poll");
        repeat (20) @(negedge clk);
        check("poll_strobe_count", recs.size(), 5);
        if (recs.size() >= 1) begin
            check("poll_first_rw", recs[0].rw, 0);
            check("poll_first_data", recs[0].data, 8'h38);
        end
        nrw = 0;
        foreach (recs[i]) if (recs[i].rw) nrw++;
        check("poll_rw_strobes", nrw, 4);
        if (recs.size() >= 2) check("poll_rs", recs[1].rs, 0);
        do_read(1'b0, rd);
        check("poll_status_idle", rd, 8'h40);
`else
        // First transfer latency and bus timing.
        do_write(1'b0, 8'h38, st);
        bus_idle();
        wait_recs(1, 100, "single");
        if (recs.size() >= 1) begin
            check("single_latency", recs[0].rise - wr_cyc, 6);
            check("single_setup", recs[0].setup, 4);
            check("single_en_len", recs[0].en_len, 12);
            check("single_hold", recs[0].hold, 4);
            check("single_rs", recs[0].rs, 0);
            check("single_rw", recs[0].rw, 0);
            check("single_data", recs[0].data, 8'h38);
        end
        repeat (40) @(negedge clk);
        check("single_no_extra", recs.size(), 1);
        recs.delete();

        // Queued table: contents, bus timing and inter-strobe spacing.
        foreach (vecs[i]) do_write(vecs[i].addr, vecs[i].data, st);
        bus_idle();
        wait_recs(7, 1000, "table");
        for (int i = 0; i < 7; i++) begin
            if (i < recs.size()) begin
                check($sformatf("vec%0d_rs", i), recs[i].rs, vecs[i].addr);
                check($sformatf("vec%0d_rw", i), recs[i].rw, 0);
                check($sformatf("vec%0d_data", i), recs[i].data, vecs[i].data);
                check($sformatf("vec%0d_setup", i), recs[i].setup, 4);
                check($sformatf("vec%0d_en_len", i), recs[i].en_len, 12);
                check($sformatf("vec%0d_hold", i), recs[i].hold, 4);
                if (i < 6 && i + 1 < recs.size())
                    check($sformatf("vec%0d_gap", i), recs[i+1].rise - recs[i].rise, vecs[i].gap);
            end
        end
        repeat (80) @(negedge clk);
        recs.delete();

        // Fill the FIFO behind a busy engine; the 17th queued byte must stall, not drop.
        do_write(1'b1, 8'h60, st);
        for (int i = 0; i < 16; i++) do_write(1'b1, 8'h61 + 8'(i), st);
        bus_idle();
        do_read(1'b1, rd);
        check("free_when_full", rd, 0);
        do_read(1'b0, rd);
        check("status_full_empty", rd[7:6], 2'b10);
        do_write(1'b1, 8'h71, st);
        bus_idle();
        check("stall_17th", st, 24);
        do_read(1'b1, rd);
        check("free_refilled", rd, 0);
        wait_recs(18, 1000, "fill");
        check("fill_strobe_count", recs.size(), 18);
        for (int i = 0; i < 18; i++) begin
            if (i < recs.size()) begin
                check($sformatf("fill%0d_data", i), recs[i].data, 8'h60 + i);
                check($sformatf("fill%0d_rs", i), recs[i].rs, 1);
            end
        end
        repeat (50) @(negedge clk);
        recs.delete();

        // Reset during the enable pulse.
        do_write(1'b0, 8'h38, st);
        do_write(1'b1, 8'h41, st);
        bus_idle();
        t = 0;
        while (!lcd_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("en_seen_before_reset", lcd_en, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_en_drop", lcd_en, 0);
        check("async_readdata", bus.readdata, 8'h40);
        check("async_on", lcd_on, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        recs.delete();
        repeat (150) @(negedge clk);
        check("no_strobe_after_reset", recs.size(), 0);
        do_read(1'b0, rd);
        check("status_after_abort", rd, 8'h40);
        do_read(1'b1, rd);
        check("free_after_abort", rd, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
